logic_reduce_unit: RTL and testbench
====================================

Name: logic_reduce_unit

Overview:
- Parametrised, registered successor to the team's single-bit gate cells.
- Applies a selectable two-input bitwise operation across CHANNELS lanes of WIDTH bits each.
- Optionally OR-accumulates results over a multi-beat burst, for sticky hit/flag detection.
- Valid/ready on both sides; sits between the operand source and any flag/status consumer.

Parameters:
- WIDTH, 8, bits per channel.
- CHANNELS, 4, number of independent lanes; bus width is CHANNELS*WIDTH.
- CNT_W, 8, width of the saturating beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit can accept a beat.
- in_a  in  CHANNELS*WIDTH  operand A; lane c = bits [c*WIDTH +: WIDTH].
- in_b  in  CHANNELS*WIDTH  operand B.
- op  in  3  operation select.
- acc_en  in  1  start an accumulating burst; sampled on the first beat only.
- in_last  in  1  final beat of a burst.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  CHANNELS*WIDTH  result.
- out_any  out  CHANNELS  per-lane reduction OR of out_y.
- out_beats  out  CNT_W  number of beats folded into out_y, saturating.

Behaviour:
- Only one clock exists. Reset is asynchronous and active-high on rst.
- Reset values:
  - out_valid=0, out_y=0, out_any=0, out_beats=0.
  - Accumulator=0, beat counter=0, latched op=000, state=IDLE.
- op encoding, bitwise per lane, f(a,b):
  - 000 AND, 001 OR, 010 XOR, 011 NAND.
  - 100 NOR, 101 XNOR, 110 A&~B, 111 pass A.
- Beat acceptance and handshake:
  - in_ready = ~out_valid | out_ready, in every state.
  - A beat is accepted when in_valid & in_ready.
  - out_valid is held until out_valid & out_ready; out_y, out_any and out_beats stay stable while out_valid=1 & out_ready=0.
  - Accept and drain in the same cycle is legal: full throughput is 1 beat/clock.
- Latency: a terminating beat accepted at edge N gives out_valid=1 from edge N (visible in cycle N+1).
- FSM: two states, IDLE and ACC.
- IDLE, accepted beat:
  - acc_en=0, or acc_en=1 with in_last=1: out_y<=f(in_a,in_b), out_beats<=1, out_valid<=1; stay in IDLE.
  - acc_en=1 with in_last=0: acc<=f(in_a,in_b), count<=1, latch op; go to ACC; out_valid unaffected by this beat.
- ACC, accepted beat:
  - Uses the latched op. The op and acc_en inputs are ignored.
  - in_last=0: acc<=acc|f; count<=sat(count+1).
  - in_last=1: out_y<=acc|f; out_beats<=sat(count+1); out_valid<=1; acc<=0; go to IDLE.
- While in ACC, an unconsumed earlier result may still be draining; in_ready throttles only via the output slot.
- out_any[c] = |out_y lane c, registered together with out_y. It is never computed combinationally from the inputs.
- Saturation: the counter stops at 2^CNT_W-1 and does not wrap; data accumulation continues.
- in_last with no burst open (IDLE, acc_en=0): treated as a single beat.
- Reset mid-burst: the partial accumulation is discarded and no output is produced.
- An out_valid pending at reset is dropped.

Test Plan:
- Reset then single beats, WIDTH=8, CHANNELS=4, out_ready=1, in_a=32'hF0F0_00FF, in_b=32'h0FF0_FF0F:
  - op=000 -> out_y=32'h00F0_000F, out_any=4'b0101, out_beats=1, one cycle after acceptance.
  - op=001 -> 32'hFFF0_FFFF.
  - op=011 -> 32'hFF0F_FFF0.
- Back-to-back 8 beats cycling op 000..111, out_ready=1 -> 8 results on consecutive cycles, in_ready constantly 1, each matching f.
- Burst of 3 beats, acc_en=1, op=010:
  - Beat values: a=01,b=00 / a=00,b=02 / a=04,b=00, in lane 0, other lanes zero.
  - Set op=000 on beats 2-3.
  - Expected: one result, out_y lane0=8'h07, out_any=4'b0001, out_beats=3 (latched op used).
- Backpressure: out_ready=0 with a result pending -> in_ready=0; out_y stable for 5 cycles; on out_ready=1, the next beat is accepted in the same cycle.
- Saturation: CNT_W=2, burst of 6 beats -> out_beats=3, out_y = OR of all 6 beat results.
- Reset asserted asynchronously mid-burst after 2 beats:
  - Outputs go to 0 immediately.
  - The following single beat, op=001, a=1, b=0, gives out_y lane0=1 and out_beats=1, with no stale accumulation.

Source files
------------

// File: rtl/logic_reduce_unit.sv
// rtl/logic_reduce_unit.sv - registered per-lane bitwise operator with optional OR-accumulating bursts
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   unit can accept a beat (output slot free or draining this cycle)
//   in_a/in_b  operands, CHANNELS lanes of WIDTH bits; lane c = [c*WIDTH +: WIDTH]
//   op         operation select (AND, OR, XOR, NAND, NOR, XNOR, A&~B, pass A)
//   acc_en     open an accumulating burst; looked at on the first beat only
//   in_last    final beat of a burst
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_y      result bus
//   out_any    per-lane OR-reduction of out_y
//   out_beats  beats folded into out_y, saturating at 2^CNT_W-1
module logic_reduce_unit #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CHANNELS*WIDTH-1:0]   in_a,
    input  logic [CHANNELS*WIDTH-1:0]   in_b,
    input  logic [2:0]                  op,
    input  logic                        acc_en,
    input  logic                        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CHANNELS*WIDTH-1:0]   out_y,
    output logic [CHANNELS-1:0]         out_any,
    output logic [CNT_W-1:0]            out_beats
);

    localparam int BUS_W = CHANNELS * WIDTH;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [BUS_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_lat_q, op_lat_d;
    logic                out_valid_q, out_valid_d;
    logic [BUS_W-1:0]    out_y_q, out_y_d;
    logic [CHANNELS-1:0] out_any_q, out_any_d;
    logic [CNT_W-1:0]    out_beats_q, out_beats_d;

    logic                beat_accept;
    logic [2:0]          cur_op;
    logic [BUS_W-1:0]    beat_f;
    logic [BUS_W-1:0]    fold_f;
    logic [CNT_W-1:0]    cnt_next;

    function automatic logic [BUS_W-1:0] apply_op(
        input logic [2:0]       sel,
        input logic [BUS_W-1:0] a,
        input logic [BUS_W-1:0] b
    );
        logic [BUS_W-1:0] r;
        case (sel)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b010:  r = a ^ b;
            3'b011:  r = ~(a & b);
            3'b100:  r = ~(a | b);
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a & ~b;
            default: r = a;
        endcase
        return r;
    endfunction

    // The output slot is the only back-pressure point: a new beat may land
    // whenever the slot is empty or is being emptied on this same edge.
    assign in_ready    = ~out_valid_q | out_ready;
    assign beat_accept = in_valid & in_ready;

    // Inside a burst the operation is frozen at what the opening beat asked for.
    assign cur_op   = (state_q == ST_ACC) ? op_lat_q : op;
    assign beat_f   = apply_op(cur_op, in_a, in_b);
    assign fold_f   = acc_q | beat_f;
    assign cnt_next = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_lat_d    = op_lat_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_beats_d = out_beats_q;
        out_any_d   = out_any_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (beat_accept) begin
            case (state_q)
                ST_IDLE: begin
                    if (!acc_en || in_last) begin
                        out_y_d     = beat_f;
                        out_beats_d = {{(CNT_W-1){1'b0}}, 1'b1};
                        out_valid_d = 1'b1;
                    end else begin
                        acc_d    = beat_f;
                        cnt_d    = {{(CNT_W-1){1'b0}}, 1'b1};
                        op_lat_d = op;
                        state_d  = ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_last) begin
                        out_y_d     = fold_f;
                        out_beats_d = cnt_next;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        acc_d = fold_f;
                        cnt_d = cnt_next;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Lane flags follow whatever value is about to be registered into out_y,
        // so they can never disagree with the held result.
        for (int c = 0; c < CHANNELS; c++) begin
            out_any_d[c] = |out_y_d[c*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            op_lat_q    <= 3'b000;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_any_q   <= '0;
            out_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            op_lat_q    <= op_lat_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_any_q   <= out_any_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_y     = out_y_q;
    assign out_any   = out_any_q;
    assign out_beats = out_beats_q;

endmodule

// File: tb/tb_logic_reduce_unit.sv
// tb/tb_logic_reduce_unit.sv - self-checking bench for logic_reduce_unit
module tb_logic_reduce_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_ready_s;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  op;
    logic        acc_en;
    logic        in_last;
    logic        out_valid;
    logic        out_valid_s;
    logic        out_ready;
    logic [31:0] out_y;
    logic [31:0] out_y_s;
    logic [3:0]  out_any;
    logic [3:0]  out_any_s;
    logic [7:0]  out_beats;
    logic [1:0]  out_beats_s;

    int n_checks = 0;
    int n_fail   = 0;

    logic_reduce_unit #(.WIDTH(8), .CHANNELS(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .op(op), .acc_en(acc_en), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
        .out_any(out_any), .out_beats(out_beats)
    );

    logic_reduce_unit #(.WIDTH(8), .CHANNELS(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .op(op), .acc_en(acc_en), .in_last(in_last),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_y(out_y_s),
        .out_any(out_any_s), .out_beats(out_beats_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic [3:0]  any;
    } vec_t;

    vec_t tbl[8];

    // Reference model state
    bit          m_valid;
    bit          m_open;
    logic [31:0] m_y;
    logic [31:0] m_acc;
    int          m_cnt;
    int          m_beats;
    logic [2:0]  m_op;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Truth-table form of each operation, indexed by {a_bit, b_bit}.
    function automatic logic [31:0] ref_f(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [3:0]  t;
        logic [31:0] r;
        case (sel)
            3'd0: t = 4'b1000;
            3'd1: t = 4'b1110;
            3'd2: t = 4'b0110;
            3'd3: t = 4'b0111;
            3'd4: t = 4'b0001;
            3'd5: t = 4'b1001;
            3'd6: t = 4'b0100;
            default: t = 4'b1100;
        endcase
        for (int i = 0; i < 32; i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic [3:0] ref_any(input logic [31:0] y);
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = ((y >> (8 * c)) & 32'hFF) != 0;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic ae, input logic l);
        in_valid = v; op = o; in_a = a; in_b = b; acc_en = ae; in_last = l;
    endtask

    task automatic model_reset();
        m_valid = 0; m_open = 0; m_y = '0; m_acc = '0; m_cnt = 0; m_beats = 0; m_op = 3'd0;
    endtask

    // Advance the model across one clock edge using the currently driven inputs.
    task automatic model_step();
        bit          acc;
        logic [31:0] fv;
        acc = in_valid && (!m_valid || out_ready);
        if (m_valid && out_ready) m_valid = 0;
        if (acc) begin
            if (!m_open) begin
                fv = ref_f(op, in_a, in_b);
                if (!acc_en || in_last) begin
                    m_y = fv; m_beats = 1; m_valid = 1;
                end else begin
                    m_open = 1; m_acc = fv; m_cnt = 1; m_op = op;
                end
            end else begin
                fv = ref_f(m_op, in_a, in_b);
                m_acc = m_acc | fv;
                m_cnt++;
                if (in_last) begin
                    m_y = m_acc; m_beats = m_cnt; m_valid = 1; m_open = 0; m_acc = '0; m_cnt = 0;
                end
            end
        end
    endtask

    initial begin
        tbl[0] = '{3'd0, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h00F0_000F, 4'b0101};
        tbl[1] = '{3'd1, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'hFFF0_FFFF, 4'b1111};
        tbl[2] = '{3'd2, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'hFF00_FFF0, 4'b1011};
        tbl[3] = '{3'd3, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'hFF0F_FFF0, 4'b1111};
        tbl[4] = '{3'd4, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h000F_0000, 4'b0100};
        tbl[5] = '{3'd5, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'h00FF_000F, 4'b0101};
        tbl[6] = '{3'd6, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'hF000_00F0, 4'b1001};
        tbl[7] = '{3'd7, 32'hF0F0_00FF, 32'h0FF0_FF0F, 32'hF0F0_00FF, 4'b1101};

        rst = 1'b1;
        out_ready = 1'b1;
        drive(0, 3'd0, '0, '0, 0, 0);
        repeat (2) @(negedge clk);
        check("reset out_valid", out_valid, 0);
        check("reset out_y", out_y, 0);
        check("reset out_any", out_any, 0);
        check("reset out_beats", out_beats, 0);
        check("reset in_ready", in_ready, 1);
        rst = 1'b0;

        // Single beats, back to back, every operation.
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check($sformatf("tbl%0d out_valid", i - 1), out_valid, 1);
                check($sformatf("tbl%0d out_y", i - 1), out_y, tbl[i-1].y);
                check($sformatf("tbl%0d out_any", i - 1), out_any, tbl[i-1].any);
                check($sformatf("tbl%0d out_beats", i - 1), out_beats, 1);
            end
            if (i < 8) drive(1, tbl[i].op, tbl[i].a, tbl[i].b, 0, 0);
            else       drive(0, 3'd0, '0, '0, 0, 0);
            #1;
            check($sformatf("b2b in_ready %0d", i), in_ready, 1);
        end
        @(negedge clk);
        check("drained out_valid", out_valid, 0);

        // Three-beat XOR burst; op changes on later beats must be ignored.
        drive(1, 3'd2, 32'h01, 32'h00, 1, 0);
        @(negedge clk);
        check("burst b1 no output", out_valid, 0);
        drive(1, 3'd0, 32'h00, 32'h02, 0, 0);
        @(negedge clk);
        check("burst b2 no output", out_valid, 0);
        drive(1, 3'd0, 32'h04, 32'h00, 0, 1);
        @(negedge clk);
        drive(0, 3'd0, '0, '0, 0, 0);
        check("burst out_valid", out_valid, 1);
        check("burst out_y", out_y, 32'h0000_0007);
        check("burst out_any", out_any, 4'b0001);
        check("burst out_beats", out_beats, 3);
        @(negedge clk);

        // Back-pressure: held result stays put, then drains and accepts together.
        out_ready = 1'b0;
        drive(1, 3'd1, 32'hF0F0_00FF, 32'h0FF0_FF0F, 0, 0);
        #1;
        check("bp first in_ready", in_ready, 1);
        @(negedge clk);
        check("bp out_valid", out_valid, 1);
        check("bp out_y", out_y, 32'hFFF0_FFFF);
        drive(1, 3'd0, 32'hF0F0_00FF, 32'h0FF0_FF0F, 0, 0);
        #1;
        check("bp in_ready low", in_ready, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp hold valid %0d", k), out_valid, 1);
            check($sformatf("bp hold y %0d", k), out_y, 32'hFFF0_FFFF);
            check($sformatf("bp hold any %0d", k), out_any, 4'b1111);
            check($sformatf("bp hold in_ready %0d", k), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", in_ready, 1);
        @(negedge clk);
        drive(0, 3'd0, '0, '0, 0, 0);
        check("bp next valid", out_valid, 1);
        check("bp next y", out_y, 32'h00F0_000F);
        check("bp next beats", out_beats, 1);
        @(negedge clk);
        check("bp drained", out_valid, 0);

        // Six-beat OR burst: 8-bit counter reads 6, 2-bit counter pins at 3.
        drive(1, 3'd1, 32'h0000_0001, 32'h0, 1, 0);
        @(negedge clk);
        drive(1, 3'd0, 32'h0000_0200, 32'h0, 0, 0);
        @(negedge clk);
        drive(1, 3'd3, 32'h0004_0000, 32'h0, 1, 0);
        @(negedge clk);
        drive(1, 3'd0, 32'h0800_0000, 32'h0, 0, 0);
        @(negedge clk);
        drive(1, 3'd6, 32'h0000_0010, 32'h0, 0, 0);
        @(negedge clk);
        drive(1, 3'd0, 32'h0000_2000, 32'h0, 0, 1);
        @(negedge clk);
        drive(0, 3'd0, '0, '0, 0, 0);
        check("sat out_y", out_y, 32'h0804_2211);
        check("sat out_any", out_any, 4'b1111);
        check("sat beats cnt8", out_beats, 6);
        check("sat beats cnt2", out_beats_s, 3);
        check("sat out_y cnt2", out_y_s, 32'h0804_2211);
        @(negedge clk);

        // Reset in the middle of a burst, away from any clock edge.
        drive(1, 3'd7, 32'h80, 32'h0, 1, 0);
        @(negedge clk);
        drive(1, 3'd7, 32'h40, 32'h0, 0, 0);
        @(negedge clk);
        drive(0, 3'd0, '0, '0, 0, 0);
        #2 rst = 1'b1;
        #1;
        check("async rst out_y", out_y, 0);
        check("async rst out_any", out_any, 0);
        check("async rst out_beats", out_beats, 0);
        check("async rst out_valid", out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        drive(1, 3'd1, 32'h1, 32'h0, 0, 1);
        @(negedge clk);
        drive(0, 3'd0, '0, '0, 0, 0);
        check("post rst valid", out_valid, 1);
        check("post rst out_y", out_y, 32'h1);
        check("post rst beats", out_beats, 1);
        @(negedge clk);

        // Randomised traffic against the reference model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            check("rnd out_valid", out_valid, m_valid);
            check("rnd out_valid cnt2", out_valid_s, m_valid);
            if (m_valid) begin
                check("rnd out_y", out_y, m_y);
                check("rnd out_any", out_any, ref_any(m_y));
                check("rnd out_beats", out_beats, (m_beats > 255) ? 255 : m_beats);
                check("rnd out_beats cnt2", out_beats_s, (m_beats > 3) ? 3 : m_beats);
            end
            out_ready = ($urandom_range(0, 9) < 7);
            drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), $urandom, $urandom,
                  ($urandom_range(0, 1) == 1), ($urandom_range(0, 9) < 3));
            #1;
            check("rnd in_ready", in_ready, (!m_valid || out_ready));
            model_step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
